// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle for the hazard/stall controller: ID/EX/MEM/WB
// register-file fields in, sequencing and forwarding controls out.
interface hazard_stall_controller_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_uses_rs;
  logic        ID_uses_rt;
  logic        ID_reads_hilo;
  logic        ID_muldiv_start;
  logic        ID_muldiv_is_div;
  logic [4:0]  EX_dest;
  logic [4:0]  MEM_dest;
  logic [4:0]  WB_dest;
  logic        EX_rf_enable;
  logic        MEM_rf_enable;
  logic        WB_rf_enable;
  logic        EX_load_instr;
  logic        EX_branch_taken;
  logic        pc_enable;
  logic        ifid_enable;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [1:0]  fwd_A_sel;
  logic [1:0]  fwd_B_sel;
  logic        hilo_busy;
  logic [15:0] stall_count;

  // Pipeline side: drives stage fields, consumes controls
  modport master (
    output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_reads_hilo,
           ID_muldiv_start, ID_muldiv_is_div,
           EX_dest, MEM_dest, WB_dest,
           EX_rf_enable, MEM_rf_enable, WB_rf_enable,
           EX_load_instr, EX_branch_taken,
    input  pc_enable, ifid_enable, ifid_flush, idex_bubble,
           fwd_A_sel, fwd_B_sel, hilo_busy, stall_count
  );

  // Controller side
  modport slave (
    input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_reads_hilo,
           ID_muldiv_start, ID_muldiv_is_div,
           EX_dest, MEM_dest, WB_dest,
           EX_rf_enable, MEM_rf_enable, WB_rf_enable,
           EX_load_instr, EX_branch_taken,
    output pc_enable, ifid_enable, ifid_flush, idex_bubble,
           fwd_A_sel, fwd_B_sel, hilo_busy, stall_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard detection, stall/flush sequencing, operand forwarding and
// HI/LO mult/div busy tracking for the 5-stage pipeline.
module hazard_stall_controller #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 8,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_hilo_busy;
  logic [15:0]      r_stall_count;

  logic       w_load_use;
  logic       w_md_stall;
  logic       w_stall;
  logic       w_issue;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Hazard terms from current inputs and busy state
  always_comb begin
    w_load_use = bus.EX_load_instr && bus.EX_rf_enable && (bus.EX_dest != 5'd0) &&
                 ((bus.ID_uses_rs && (bus.ID_rs == bus.EX_dest)) ||
                  (bus.ID_uses_rt && (bus.ID_rt == bus.EX_dest)));
    w_md_stall = r_hilo_busy && (bus.ID_reads_hilo || bus.ID_muldiv_start);
    w_stall    = w_load_use || w_md_stall;
    w_issue    = bus.ID_muldiv_start && !w_stall;
  end

  // Forwarding selects, nearest producing stage wins; $0 never forwards
  always_comb begin
    w_fwd_a = 2'b00;
    if (bus.ID_rs != 5'd0) begin
      if (bus.EX_rf_enable && (bus.EX_dest == bus.ID_rs))        w_fwd_a = 2'b01;
      else if (bus.MEM_rf_enable && (bus.MEM_dest == bus.ID_rs)) w_fwd_a = 2'b10;
      else if (bus.WB_rf_enable && (bus.WB_dest == bus.ID_rs))   w_fwd_a = 2'b11;
    end
    w_fwd_b = 2'b00;
    if (bus.ID_rt != 5'd0) begin
      if (bus.EX_rf_enable && (bus.EX_dest == bus.ID_rt))        w_fwd_b = 2'b01;
      else if (bus.MEM_rf_enable && (bus.MEM_dest == bus.ID_rt)) w_fwd_b = 2'b10;
      else if (bus.WB_rf_enable && (bus.WB_dest == bus.ID_rt))   w_fwd_b = 2'b11;
    end
  end

  // Mult/div busy FSM: load latency on issue, count down to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_hilo_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_count     <= bus.ID_muldiv_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            r_state     <= ST_BUSY;
            r_hilo_busy <= 1'b1;
          end
        end
        ST_BUSY: begin
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state     <= ST_IDLE;
            r_hilo_busy <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_count     <= '0;
          r_hilo_busy <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  // A taken branch still redirects the PC while stalled; IF/ID holds the
  // delay slot then, so the wrong-path fetch is never latched and no flush
  // is issued.
  assign bus.pc_enable   = !w_stall || bus.EX_branch_taken;
  assign bus.ifid_enable = !w_stall;
  assign bus.idex_bubble = w_stall;
  assign bus.ifid_flush  = bus.EX_branch_taken && !w_stall;
  assign bus.fwd_A_sel   = w_fwd_a;
  assign bus.fwd_B_sel   = w_fwd_b;
  assign bus.hilo_busy   = r_hilo_busy;
  assign bus.stall_count = r_stall_count;

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller for the 5-stage core. It sits beside the IF/ID and ID/EX stage registers and generates the following controls:
- PC and IF/ID enables
- the ID/EX bubble
- IF/ID flush
- operand-forwarding selects for the ID_muxA/ID_muxB paths

It tracks the multi-cycle HI/LO multiply/divide unit with an internal busy counter, stalls dependent instructions, and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MULT_LAT, 4, busy cycles for a mult/multu
- DIV_LAT, 8, busy cycles for a div/divu
- CNT_W, 6, busy counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ID_rs  in  5  rs field of instruction in ID
- ID_rt  in  5  rt field of instruction in ID
- ID_uses_rs / ID_uses_rt  in  1 each  ID instruction reads rs / rt
- ID_reads_hilo  in  1  ID instruction is mfhi/mflo
- ID_muldiv_start  in  1  ID instruction is mult/multu/div/divu
- ID_muldiv_is_div  in  1  qualifies ID_muldiv_start: 1 = div, 0 = mult
- EX_dest / MEM_dest / WB_dest  in  5 each  destination register per stage
- EX_rf_enable / MEM_rf_enable / WB_rf_enable  in  1 each  stage writes the register file
- EX_load_instr  in  1  EX instruction is a load
- EX_branch_taken  in  1  condition handler resolved a taken branch/jump in EX
- pc_enable  out  1  PC register load enable
- ifid_enable  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads NOP at next edge
- idex_bubble  out  1  ID/EX loads all-zero control_signals at next edge
- fwd_A_sel / fwd_B_sel  out  2 each  00 = regfile, 01 = EX, 10 = MEM, 11 = WB
- hilo_busy  out  1  mult/div in progress
- stall_count  out  16  saturating count of stalled cycles

## Operation
**Hazard terms.** All are combinational from inputs and current state. Register 0 is never a hazard or forward source.
- load_use = EX_load_instr & EX_rf_enable & EX_dest≠0 & ((ID_uses_rs & ID_rs==EX_dest) | (ID_uses_rt & ID_rt==EX_dest)).
- md_stall = hilo_busy & (ID_reads_hilo | ID_muldiv_start).
- stall = load_use | md_stall.

**Outputs.**
- pc_enable = ~stall | EX_branch_taken.
- ifid_enable = ~stall.
- idex_bubble = stall.
- ifid_flush = EX_branch_taken & ~stall. The delay slot in ID always proceeds; the wrong-path instruction in IF is discarded.
- Branch taken while stalled: the PC loads the target, and IF/ID holds the delay slot. No flush is needed because the wrong-path fetch is never latched.

**Forwarding, per operand (rs → A, rt → B).**
- Priority: EX match with EX_rf_enable → 01; else MEM → 10; else WB → 11; else 00.
- Outputs are don't-care while stall=1.

**Mult/div FSM.**
- States: IDLE (count = 0), BUSY (count ≠ 0). hilo_busy = (state == BUSY).
- Issue condition: ID_muldiv_start & ~stall. On an issue edge, count ← DIV_LAT if ID_muldiv_is_div, else MULT_LAT; state → BUSY.
- In BUSY, count decrements by 1 each edge and returns to IDLE when it reaches 0.
- Issue in BUSY is impossible, because md_stall holds the instruction in ID.

**stall_count.** Increments by 1 on each edge where stall=1. It saturates at 0xFFFF.

**Reset.**
- count = 0, state = IDLE, stall_count = 0. Reset mid-operation abandons any in-progress mult/div.
- Outputs during and after reset, given idle inputs: pc_enable = 1, ifid_enable = 1, ifid_flush = 0, idex_bubble = 0, fwd sels = 00, hilo_busy = 0.

## Timing
- All control outputs are combinational and same-cycle, so they must settle before the stage registers' edge.
- Load-use: exactly 1 bubble. On the next cycle the load is in MEM and the operand forwards with select 10.
- Mult/div issued at edge E:
  - hilo_busy is high for cycles E+1 … E+LAT (LAT cycles).
  - A dependent mfhi/mflo or mult/div in ID stalls through cycle E+LAT and proceeds at the edge ending the first cycle where hilo_busy = 0.
- When load_use and md_stall are true together, the instruction stalls for the longer of the two. Each stalled cycle counts once in stall_count.

## Test plan
- **Load-use:** EX = lw to $5, ID = add reading rs = 5 → one cycle of stall=1, idex_bubble=1, pc_enable=0; next cycle fwd_A_sel=10, stall=0; stall_count=1.
- **Forward priority:** EX_dest = MEM_dest = WB_dest = 7, all rf_enable=1, ID_rt=7, ID_uses_rt=1 → fwd_B_sel=01. Drop EX_rf_enable → 10. ID_rt=0 → 00.
- **Divide:**
  - Issue div at edge E with DIV_LAT=8; mflo in ID at E+1 → stall for 8 cycles, hilo_busy deasserts after edge E+8, mflo advances at edge E+9.
  - Issue mult → 4 busy cycles.
- **Branch:**
  - EX_branch_taken=1, no stall → ifid_flush=1, pc_enable=1.
  - Same cycle with md_stall → pc_enable=1, ifid_enable=0, ifid_flush=0.
- **Reset mid-op:** assert reset 3 cycles into a div → next cycle hilo_busy=0, stall_count=0, mflo in ID proceeds with no stall.
- **Saturation:** hold md_stall continuously, re-issuing divs, for >65535 stalled cycles → stall_count holds at 0xFFFF.
